// File: rtl/link_param_loader_pkg.sv
// Shared types and constants for the neighbour-link parameter loader.
// Stage codes mirror the global stage encoding used across the array.
package link_param_loader_pkg;

  localparam int unsigned STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE               = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RUN                = 3'd2;

  // Boundary condition codes carried with each link record.
  localparam logic [1:0] BC_NONE     = 2'd0;
  localparam logic [1:0] BC_BOUNDARY = 2'd1;
  localparam logic [1:0] BC_ABSENT   = 2'd2;
  localparam logic [1:0] BC_RESERVED = 2'd3;

  // Record width is LINK_BIT_WIDTH + 2 (boundary code above weight).
  localparam int unsigned BC_WIDTH = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/link_param_loader_if.sv
// Per-link parameter record stream (valid/ready).
//   master: record source (drives valid/weight/boundary, sees ready)
//   slave : loader (consumes records, drives ready)
interface link_param_loader_if #(
  parameter int unsigned IN_WEIGHT_WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [IN_WEIGHT_WIDTH-1:0] in_weight;
  logic [1:0]                 in_boundary;

  modport master (output in_valid, output in_weight, output in_boundary, input in_ready);
  modport slave  (input in_valid, input in_weight, input in_boundary, output in_ready);
endinterface

// File: rtl/link_param_loader_buffer.sv
// link_param_buffer: DEPTH x REC_W register array, one write port and one
// registered read port. The read register is the loader's output stage.
//   we/wr_addr/wr_data : write port
//   rd_en/rd_addr      : load rd_data from the array on the next edge
//   rd_clr             : clear rd_data (takes priority over rd_en)
module link_param_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned REC_W  = 4,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [REC_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [REC_W-1:0]  rd_data
);

  logic [REC_W-1:0] mem [DEPTH];

  // Storage array; contents only matter once a full set has been written.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read with write-through so a same-cycle write is visible.
  always_ff @(posedge clk) begin
    if (reset || rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/link_param_loader.sv
// link_param_loader: buffers a full chain of link parameter records from a
// valid/ready stream, requests the parameter-loading stage, then shifts one
// record per cycle into the link chain. The buffer is kept for replay.
//   clk, reset             : clock, synchronous active-high reset
//   global_stage           : global stage code
//   rec (slave)            : record stream in_valid/in_ready/in_weight/in_boundary
//   flush                  : discard buffer, clear sticky flags, back to FILL
//   load_req               : buffer full, waiting for the loading stage
//   load_done              : pulse during the last shift cycle
//   params_valid           : chain holds a complete parameter set
//   load_error             : sticky, stage ended before the chain was full
//   sat_warn               : sticky, weight saturated or reserved boundary seen
//   weight_out             : to first link's weight_in
//   boundary_condition_out : to first link's boundary_condition_in
module link_param_loader
  import link_param_loader_pkg::*;
#(
  parameter  int unsigned MAX_WEIGHT      = 2,
  parameter  int unsigned NUM_LINKS       = 16,
  parameter  int unsigned IN_WEIGHT_WIDTH = 8,
  localparam int unsigned LINK_BIT_WIDTH  = $clog2(MAX_WEIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STAGE_WIDTH-1:0]    global_stage,
  link_param_loader_if.slave        rec,
  input  logic                      flush,
  output logic                      load_req,
  output logic                      load_done,
  output logic                      params_valid,
  output logic                      load_error,
  output logic                      sat_warn,
  output logic [LINK_BIT_WIDTH-1:0] weight_out,
  output logic [1:0]                boundary_condition_out
);

  localparam int unsigned REC_W  = LINK_BIT_WIDTH + BC_WIDTH;
  localparam int unsigned CNT_W  = $clog2(NUM_LINKS + 1);
  localparam int unsigned ADDR_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(NUM_LINKS);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(NUM_LINKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  loader_state_e state, state_n;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_n;
  logic [CNT_W-1:0] rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] shift_cnt, shift_cnt_n;

  logic stage_pl, flush_ok, accept;
  logic w_over, bc_rsv;
  logic [LINK_BIT_WIDTH-1:0] w_sat;
  logic [1:0]                bc_sat;

  logic              we;
  logic [REC_W-1:0]  wr_data;
  logic              rd_en, rd_clr;
  logic [ADDR_W-1:0] rd_addr;
  logic [REC_W-1:0]  rd_data;

  logic in_ready_d, load_req_d, load_done_d, params_valid_d, load_error_d, sat_warn_d;

  assign stage_pl = (global_stage == STAGE_PARAMETERS_LOADING);
  // The loading stage always wins over a coincident flush.
  assign flush_ok = flush && !stage_pl;
  assign accept   = rec.in_valid && rec.in_ready && (state == FILL);

  // Input saturation: clamp weight, map reserved boundary code to absent.
  assign w_over  = (rec.in_weight > IN_WEIGHT_WIDTH'(MAX_WEIGHT));
  assign bc_rsv  = (rec.in_boundary == BC_RESERVED);
  assign w_sat   = w_over ? LINK_BIT_WIDTH'(MAX_WEIGHT) : LINK_BIT_WIDTH'(rec.in_weight);
  assign bc_sat  = bc_rsv ? BC_ABSENT : rec.in_boundary;
  assign wr_data = {bc_sat, w_sat};
  assign we      = accept && !flush_ok;

  link_param_buffer #(
    .DEPTH  (NUM_LINKS),
    .REC_W  (REC_W),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_addr (ADDR_W'(wr_cnt)),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign weight_out             = rd_data[LINK_BIT_WIDTH-1:0];
  assign boundary_condition_out = rd_data[REC_W-1 -: BC_WIDTH];

  // State and counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      shift_cnt <= '0;
    end else begin
      state     <= state_n;
      wr_cnt    <= wr_cnt_n;
      rd_ptr    <= rd_ptr_n;
      shift_cnt <= shift_cnt_n;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_n     = state;
    wr_cnt_n    = wr_cnt;
    rd_ptr_n    = rd_ptr;
    shift_cnt_n = shift_cnt;
    case (state)
      FILL: begin
        if (flush_ok) begin
          wr_cnt_n = '0;
        end else if (accept) begin
          wr_cnt_n = wr_cnt + CNT_ONE;
          if (wr_cnt_n == FULL_CNT) begin
            state_n  = READY;
            rd_ptr_n = CNT_ONE;
          end
        end
      end
      READY: begin
        // Stage cycle 0 is sampled from READY, so SHIFT starts with one
        // record already delivered.
        if (stage_pl) begin
          state_n     = SHIFT;
          rd_ptr_n    = rd_ptr + CNT_ONE;
          shift_cnt_n = CNT_ONE;
        end else if (flush_ok) begin
          state_n  = FILL;
          wr_cnt_n = '0;
          rd_ptr_n = '0;
        end
      end
      SHIFT: begin
        // Stage dropping before the last record was sampled is an error.
        if (!stage_pl) begin
          state_n     = FILL;
          wr_cnt_n    = '0;
          rd_ptr_n    = '0;
          shift_cnt_n = '0;
        end else if (shift_cnt == LAST_SHIFT) begin
          state_n     = DONE;
          rd_ptr_n    = '0;
          shift_cnt_n = '0;
        end else begin
          rd_ptr_n    = rd_ptr + CNT_ONE;
          shift_cnt_n = shift_cnt + CNT_ONE;
        end
      end
      DONE: begin
        // rd_ptr == 1 marks entry 0 as preloaded; replay only from there so
        // a stage that lingers after the load does not restart it.
        if (stage_pl) begin
          if (rd_ptr == CNT_ONE) begin
            state_n     = SHIFT;
            rd_ptr_n    = rd_ptr + CNT_ONE;
            shift_cnt_n = CNT_ONE;
          end
        end else if (flush_ok) begin
          state_n  = FILL;
          wr_cnt_n = '0;
          rd_ptr_n = '0;
        end else begin
          rd_ptr_n = CNT_ONE;
        end
      end
      default: state_n = FILL;
    endcase
  end

  // Output logic: read-port control and next values of the flag registers.
  always_comb begin
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    rd_addr = '0;
    if (state_n == SHIFT) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(rd_ptr);
    end else if ((state == FILL) && (state_n == READY)) begin
      rd_en = 1'b1;
    end else if ((state == DONE) && (state_n == DONE) && !stage_pl) begin
      rd_en = 1'b1;
    end else if ((state_n == FILL) || (state == SHIFT)) begin
      rd_clr = 1'b1;
    end

    in_ready_d  = (state_n == FILL);
    load_req_d  = (state_n == READY);
    load_done_d = (state_n == SHIFT) && (shift_cnt_n == LAST_SHIFT);

    params_valid_d = params_valid;
    if ((state == SHIFT) && (state_n == DONE)) params_valid_d = 1'b1;
    if (state_n == FILL)                       params_valid_d = 1'b0;

    load_error_d = load_error;
    sat_warn_d   = sat_warn;
    if (flush_ok && (state != SHIFT)) begin
      load_error_d = 1'b0;
      sat_warn_d   = 1'b0;
    end else begin
      if ((state == SHIFT) && !stage_pl) load_error_d = 1'b1;
      if (accept && (w_over || bc_rsv))  sat_warn_d   = 1'b1;
    end
  end

  // Output flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec.in_ready <= 1'b0;
      load_req     <= 1'b0;
      load_done    <= 1'b0;
      params_valid <= 1'b0;
      load_error   <= 1'b0;
      sat_warn     <= 1'b0;
    end else begin
      rec.in_ready <= in_ready_d;
      load_req     <= load_req_d;
      load_done    <= load_done_d;
      params_valid <= params_valid_d;
      load_error   <= load_error_d;
      sat_warn     <= sat_warn_d;
    end
  end

endmodule

// File: doc/link_param_loader.md
Name: link_param_loader

Overview:
- Upstream feeder for the neighbour-link parameter shift chain.
- Accepts per-link parameter records (weight, boundary condition) over a valid/ready stream and buffers a full chain's worth.
- Requests the parameter-loading stage, then drives the chain's weight/boundary inputs one record per cycle while global_stage == STAGE_PARAMETERS_LOADING.
- Retains the buffer so the same parameter set can be replayed on the next load.

Parameters:
MAX_WEIGHT, 2, maximum link weight; LINK_BIT_WIDTH = $clog2(MAX_WEIGHT+1)
NUM_LINKS, 16, number of links in the shift chain; also the buffer depth
IN_WEIGHT_WIDTH, 8, width of the incoming weight field before saturation

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
global_stage  in  STAGE_WIDTH  global stage code (stage constants from parameters.sv)
in_valid  in  1  record valid
in_ready  out  1  record accepted when in_valid && in_ready
in_weight  in  IN_WEIGHT_WIDTH  raw link weight
in_boundary  in  2  boundary condition: 0 none, 1 boundary, 2 non-existent, 3 reserved
flush  in  1  discard buffer, return to FILL
load_req  out  1  buffer full, requesting STAGE_PARAMETERS_LOADING
load_done  out  1  one-cycle pulse on the last shift cycle
params_valid  out  1  chain holds a complete parameter set
load_error  out  1  sticky: stage ended before NUM_LINKS shifts
sat_warn  out  1  sticky: weight saturated or in_boundary == 3 received
weight_out  out  LINK_BIT_WIDTH  to first link's weight_in
boundary_condition_out  out  2  to first link's boundary_condition_in

Behaviour:
- Reset values (sync):
  - state FILL; wr_cnt, rd_ptr, shift_cnt = 0.
  - All outputs 0, including in_ready. in_ready is held 0 while reset is high.
- Buffer: NUM_LINKS entries of {bc[1:0], weight}, FIFO order. The first record accepted ends up in the deepest link (position NUM_LINKS-1).
- Input rules:
  - Weights: in_weight > MAX_WEIGHT stores MAX_WEIGHT and sets sat_warn.
  - Boundary: in_boundary == 3 stores 2 and sets sat_warn.
  - sat_warn and load_error clear only on reset or flush.
- FILL:
  - in_ready = 1. Each accepted record is written at wr_cnt, then wr_cnt increments.
  - On the accept that makes wr_cnt == NUM_LINKS: next state READY.
- READY:
  - in_ready = 0, load_req = 1.
  - Output registers hold entry 0, rd_ptr = 1.
  - When global_stage == STAGE_PARAMETERS_LOADING: next state SHIFT.
- SHIFT (entered on the first cycle of the stage):
  - The link samples on the same edge that the output registers advance, so stage cycle k delivers entry k. Latency is 0 from stage entry.
  - shift_cnt counts sampled cycles. On the cycle where shift_cnt == NUM_LINKS-1 and the stage is still loading:
    - load_done = 1 for one cycle;
    - next state DONE; outputs cleared to 0.
  - Stage leaves loading with shift_cnt < NUM_LINKS-1: load_error = 1, buffer invalidated (wr_cnt = 0), next state FILL, outputs 0.
  - flush is ignored in SHIFT.
- DONE:
  - params_valid = 1; load_req = 0; in_ready = 0.
  - Output registers reloaded with entry 0, rd_ptr = 1.
  - Re-entry to STAGE_PARAMETERS_LOADING replays the buffer (SHIFT again); params_valid stays 1.
- flush:
  - Honoured in FILL, READY and DONE, and only when global_stage != STAGE_PARAMETERS_LOADING. If both occur in the same cycle, the stage wins.
  - Effect: wr_cnt = 0, params_valid = 0, sticky flags cleared, next state FILL.
- Outputs outside SHIFT/READY/DONE-preload are 0, so the non-existent condition is never presented.
- Counters: wr_cnt, shift_cnt and rd_ptr are $clog2(NUM_LINKS+1) bits wide. None wraps; all are cleared on state entry.

Decomposition:
- Shared package: loader state enum (FILL, READY, SHIFT, DONE); record width LINK_BIT_WIDTH+2; boundary code constants BC_NONE=0, BC_BOUNDARY=1, BC_ABSENT=2.
- Stage codes come from the existing parameters.sv.
- One sub-module: link_param_buffer, a NUM_LINKS × record-width register array with one write port and one registered read port.

Test Plan:
1. NUM_LINKS=4. Push (1,0),(2,1),(0,2),(2,0) with in_valid held high -> in_ready falls and load_req=1 the cycle after the 4th accept. Assert stage PL for 4 cycles -> link samples (1,0),(2,1),(0,2),(2,0) in order; load_done pulses in cycle 4; params_valid=1; outputs 0 afterwards.
2. Push in_weight=5 with bc=3 -> stored (2,2); sat_warn=1 and stays 1 until flush.
3. From READY, hold PL for only 2 cycles -> load_error=1, state FILL, in_ready=1, params_valid=0; a new fill needs 4 records.
4. In DONE, re-enter PL for 4 cycles -> identical sequence replayed; load_done pulses again; no records consumed.
5. Assert reset in SHIFT cycle 2 -> next cycle all outputs 0, state FILL; in_ready=1 once reset deasserts.
6. flush in READY -> load_req=0, FILL. flush in the same cycle as PL entry from READY -> flush ignored, SHIFT proceeds normally.
